mult_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one shift-add multiplier core between N requesters.
- The core has a Start/Ready handshake, L_word-bit operands and a 2*L_word-bit product.
- Per requester, the block accepts an operand pair, drives the core's Start and operand inputs, and waits for completion. It then returns the product to the owning requester with a one-cycle done pulse.
- Sits between the requesting units and the multiplier core; the core's own reset is driven from the top level.

---
 rtl/mult_rr_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_rr_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_arbiter.sv
// Round-robin front end sharing one shift-add multiplier core.
// Grants one requester at a time and returns its product with a done pulse.
module mult_rr_arbiter #(
    parameter int N       = 4,
    parameter int L_word  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N*L_word-1:0]   req_word1,
    input  logic [N*L_word-1:0]   req_word2,
    output logic [N-1:0]          gnt,
    output logic [N-1:0]          done,
    output logic [2*L_word-1:0]   result,
    output logic                  err,
    output logic                  mul_start,
    output logic [L_word-1:0]     mul_word1,
    output logic [L_word-1:0]     mul_word2,
    input  logic                  mul_ready,
    input  logic [2*L_word-1:0]   mul_product
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PW:0]   NV       = (PW+1)'(N);
    localparam logic [PW-1:0] LAST     = PW'(N - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    logic [1:0]        state;
    logic [PW-1:0]     pointer;
    logic [PW-1:0]     owner;
    logic [CW-1:0]     wcnt;

    logic [2*N-1:0]    dbl;
    logic [PW-1:0]     off;
    logic              hit;
    logic [PW:0]       sum;
    logic [PW:0]       diff;
    logic [PW-1:0]     win;
    logic [PW-1:0]     ptr_nxt;
    logic [N-1:0]      win_oh;
    logic [N-1:0]      own_oh;
    logic [L_word-1:0] op1;
    logic [L_word-1:0] op2;

    assign mul_start = (state == S_ISSUE);

    // Rotate requests so the pointer sits at bit 0, then take the first set bit.
    always_comb begin
        dbl = {req, req} >> pointer;
        off = '0;
        hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!hit && dbl[k]) begin
                hit = 1'b1;
                off = PW'(k);
            end
        end
        sum     = {1'b0, pointer} + {1'b0, off};
        diff    = sum - NV;
        win     = (sum >= NV) ? diff[PW-1:0] : sum[PW-1:0];
        ptr_nxt = (win == LAST) ? '0 : win + PW'(1);
    end

    // Decode winner/owner into one-hot vectors and select the winner's operands.
    always_comb begin
        win_oh = '0;
        own_oh = '0;
        op1    = '0;
        op2    = '0;
        for (int k = 0; k < N; k++) begin
            win_oh[k] = (win == PW'(k));
            own_oh[k] = (owner == PW'(k));
            if (win == PW'(k)) begin
                op1 = req_word1[k*L_word +: L_word];
                op2 = req_word2[k*L_word +: L_word];
            end
        end
    end

    // Sequencer: arbitrate, issue to the core, wait with timeout, report.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            pointer   <= '0;
            owner     <= '0;
            wcnt      <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            result    <= '0;
            mul_word1 <= '0;
            mul_word2 <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (|req) begin
                        mul_word1 <= op1;
                        mul_word2 <= op2;
                        owner     <= win;
                        gnt       <= win_oh;
                        pointer   <= ptr_nxt;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mul_ready) begin
                        wcnt  <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (mul_ready) begin
                        result <= mul_product;
                        done   <= own_oh;
                        state  <= S_DONE;
                    end else if (wcnt == LAST_CNT) begin
                        result <= '0;
                        done   <= own_oh;
                        err    <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Self-checking bench for mult_rr_arbiter with a behavioural multiplier core.
// Expected grants, products and latencies come from a simple request model.
module tb_mult_rr_arbiter;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int TO = 15;
    localparam int P2 = 2 * L;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*L-1:0]  w1;
    logic [N*L-1:0]  w2;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [P2-1:0]   result;
    logic            err;
    logic            mul_start;
    logic [L-1:0]    mul_word1;
    logic [L-1:0]    mul_word2;
    logic            mul_ready;
    logic [P2-1:0]   mul_product;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mptr  = 0;
    bit stall = 1'b0;
    int busy;

    mult_rr_arbiter #(.N(N), .L_word(L), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req(req), .req_word1(w1), .req_word2(w2),
        .gnt(gnt), .done(done), .result(result), .err(err),
        .mul_start(mul_start), .mul_word1(mul_word1), .mul_word2(mul_word2),
        .mul_ready(mul_ready), .mul_product(mul_product)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Core model: zero operand flushes and stays ready, else busy L+1 cycles.
    always @(posedge clock) begin
        if (!reset) begin
            mul_ready   <= 1'b1;
            mul_product <= '0;
            busy        <= 0;
        end else if (mul_ready && mul_start) begin
            if (mul_word1 == 0 || mul_word2 == 0) begin
                mul_product <= '0;
            end else begin
                mul_ready   <= 1'b0;
                busy        <= L + 1;
                mul_product <= P2'(mul_word1) * P2'(mul_word2);
            end
        end else if (!mul_ready && !stall) begin
            if (busy == 1) mul_ready <= 1'b1;
            busy <= busy - 1;
        end
    end

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        w1[i*L +: L] = L'(a);
        w2[i*L +: L] = L'(b);
    endtask

    task automatic wait_gnt(output logic [N-1:0] gv, output int c,
                            output logic ms);
        bit f;
        f  = 1'b0;
        gv = 'x;
        c  = -1000;
        ms = 1'bx;
        for (int k = 0; k < 64 && !f; k++) begin
            @(negedge clock);
            if (gnt != 0) begin
                f  = 1'b1;
                gv = gnt;
                c  = cyc;
                ms = mul_start;
            end
        end
    endtask

    task automatic wait_done(output logic [N-1:0] dv, output logic [P2-1:0] r,
                             output logic e, output int c);
        bit f;
        f  = 1'b0;
        dv = 'x;
        r  = 'x;
        e  = 1'bx;
        c  = 1000;
        for (int k = 0; k < 64 && !f; k++) begin
            @(negedge clock);
            if (done != 0) begin
                f  = 1'b1;
                dv = done;
                r  = result;
                e  = err;
                c  = cyc;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '0;
        w1    = '0;
        w2    = '0;
        repeat (3) @(negedge clock);
        n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rst_gnt: got %b want 0", gnt); end
        n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
        n_cmp++; if (mul_start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %b want 0", mul_start); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL rst_result: got %0d want 0", result); end
        n_cmp++; if (mul_word1 !== '0) begin n_bad++; $display("FAIL rst_w1: got %0d want 0", mul_word1); end
        n_cmp++; if (mul_word2 !== '0) begin n_bad++; $display("FAIL rst_w2: got %0d want 0", mul_word2); end
        mptr  = 0;
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  gv, dv;
        logic [P2-1:0] r, xr;
        logic          e, ms;
        int            cg, cd, ex;
        for (int i = 0; i < N; i++) set_op(i, 2*i + 1, 2*i + 2);
        req = '1;
        for (int t = 0; t < 5; t++) begin
            ex   = pick('1, mptr);
            mptr = (ex + 1) % N;
            xr   = P2'((2*ex + 1) * (2*ex + 2));
            wait_gnt(gv, cg, ms);
            if (t == 4) req = '0;
            n_cmp++; if (gv !== oh(ex)) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", t, gv, oh(ex)); end
            wait_done(dv, r, e, cd);
            n_cmp++; if (dv !== oh(ex)) begin n_bad++; $display("FAIL rr_done[%0d]: got %b want %b", t, dv, oh(ex)); end
            n_cmp++; if (r !== xr) begin n_bad++; $display("FAIL rr_result[%0d]: got %0d want %0d", t, r, xr); end
            n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rr_err[%0d]: got %b want 0", t, e); end
            @(negedge clock);
            n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL rr_pulse[%0d]: got %b want 0", t, done); end
            n_cmp++; if (result !== xr) begin n_bad++; $display("FAIL rr_hold[%0d]: got %0d want %0d", t, result, xr); end
        end
    endtask

    task automatic test_single();
        logic [N-1:0]  gv, dv;
        logic [P2-1:0] r;
        logic          e, ms;
        int            cg, cd, ex;
        set_op(0, 13, 11);
        req  = 4'b0001;
        ex   = pick(req, mptr);
        mptr = (ex + 1) % N;
        wait_gnt(gv, cg, ms);
        req = '0;
        n_cmp++; if (gv !== oh(ex)) begin n_bad++; $display("FAIL single_gnt: got %b want %b", gv, oh(ex)); end
        n_cmp++; if (ms !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", ms); end
        wait_done(dv, r, e, cd);
        n_cmp++; if (dv !== oh(ex)) begin n_bad++; $display("FAIL single_done: got %b want %b", dv, oh(ex)); end
        n_cmp++; if (r !== P2'(143)) begin n_bad++; $display("FAIL single_result: got %0d want 143", r); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", e); end
        n_cmp++; if (cd - cg != L + 3) begin n_bad++; $display("FAIL single_lat: got %0d want %0d", cd - cg, L + 3); end
        @(negedge clock);
        n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL single_pulse: got %b want 0", done); end
    endtask

    task automatic test_zero();
        logic [N-1:0]  gv, dv;
        logic [P2-1:0] r;
        logic          e, ms;
        int            cg, cd, ex;
        set_op(2, 0, 9);
        req  = 4'b0100;
        ex   = pick(req, mptr);
        mptr = (ex + 1) % N;
        wait_gnt(gv, cg, ms);
        req = '0;
        n_cmp++; if (gv !== oh(ex)) begin n_bad++; $display("FAIL zero_gnt: got %b want %b", gv, oh(ex)); end
        wait_done(dv, r, e, cd);
        n_cmp++; if (dv !== oh(ex)) begin n_bad++; $display("FAIL zero_done: got %b want %b", dv, oh(ex)); end
        n_cmp++; if (r !== '0) begin n_bad++; $display("FAIL zero_result: got %0d want 0", r); end
        n_cmp++; if (cd - cg != 2) begin n_bad++; $display("FAIL zero_lat: got %0d want 2", cd - cg); end
        @(negedge clock);
        set_op(2, 15, 15);
        req  = 4'b0100;
        ex   = pick(req, mptr);
        mptr = (ex + 1) % N;
        wait_gnt(gv, cg, ms);
        req = '0;
        wait_done(dv, r, e, cd);
        n_cmp++; if (r !== P2'(225)) begin n_bad++; $display("FAIL max_result: got %0d want 225", r); end
        n_cmp++; if (cd - cg != L + 3) begin n_bad++; $display("FAIL max_lat: got %0d want %0d", cd - cg, L + 3); end
        @(negedge clock);
    endtask

    task automatic test_wrap();
        logic [N-1:0]  gv, dv;
        logic [P2-1:0] r, xr;
        logic          e, ms;
        logic [N-1:0]  pend;
        int            cg, cd, ex;
        set_op(0, 3, 5);
        set_op(2, 6, 7);
        req  = 4'b0101;
        pend = req;
        for (int t = 0; t < 2; t++) begin
            ex       = pick(pend, mptr);
            mptr     = (ex + 1) % N;
            pend[ex] = 1'b0;
            xr       = (ex == 0) ? P2'(15) : P2'(42);
            wait_gnt(gv, cg, ms);
            req[ex] = 1'b0;
            n_cmp++; if (gv !== oh(ex)) begin n_bad++; $display("FAIL wrap_gnt[%0d]: got %b want %b", t, gv, oh(ex)); end
            wait_done(dv, r, e, cd);
            n_cmp++; if (r !== xr) begin n_bad++; $display("FAIL wrap_result[%0d]: got %0d want %0d", t, r, xr); end
        end
        @(negedge clock);
    endtask

    task automatic test_timeout();
        logic [N-1:0]  gv, dv;
        logic [P2-1:0] r;
        logic          e, ms;
        int            cg, cd, ex;
        set_op(3, 9, 9);
        stall = 1'b1;
        req   = 4'b1000;
        ex    = pick(req, mptr);
        mptr  = (ex + 1) % N;
        wait_gnt(gv, cg, ms);
        req = '0;
        wait_done(dv, r, e, cd);
        stall = 1'b0;
        n_cmp++; if (dv !== oh(ex)) begin n_bad++; $display("FAIL to_done: got %b want %b", dv, oh(ex)); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", e); end
        n_cmp++; if (r !== '0) begin n_bad++; $display("FAIL to_result: got %0d want 0", r); end
        n_cmp++; if (cd - cg != TO + 1) begin n_bad++; $display("FAIL to_lat: got %0d want %0d", cd - cg, TO + 1); end
        @(negedge clock);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_errpulse: got %b want 0", err); end
        set_op(1, 6, 7);
        req  = 4'b0010;
        ex   = pick(req, mptr);
        mptr = (ex + 1) % N;
        wait_gnt(gv, cg, ms);
        req = '0;
        n_cmp++; if (gv !== oh(ex)) begin n_bad++; $display("FAIL to_next_gnt: got %b want %b", gv, oh(ex)); end
        wait_done(dv, r, e, cd);
        n_cmp++; if (r !== P2'(42)) begin n_bad++; $display("FAIL to_next_result: got %0d want 42", r); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL to_next_err: got %b want 0", e); end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0]  gv, dv;
        logic [P2-1:0] r;
        logic          e, ms;
        int            cg, cd, ex, seen;
        set_op(1, 5, 3);
        req  = 4'b0010;
        ex   = pick(req, mptr);
        wait_gnt(gv, cg, ms);
        req = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        mptr  = 0;
        n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL mid_done: got %b want 0", done); end
        n_cmp++; if (mul_start !== 1'b0) begin n_bad++; $display("FAIL mid_start: got %b want 0", mul_start); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL mid_result: got %0d want 0", result); end
        n_cmp++; if (mul_word1 !== '0 || mul_word2 !== '0) begin n_bad++; $display("FAIL mid_words: got %0d,%0d want 0,0", mul_word1, mul_word2); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done != 0) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mid_silent: got %0d done pulses want 0", seen); end
        req  = 4'b0010;
        ex   = pick(req, mptr);
        mptr = (ex + 1) % N;
        wait_gnt(gv, cg, ms);
        req = '0;
        n_cmp++; if (gv !== oh(ex)) begin n_bad++; $display("FAIL mid_next_gnt: got %b want %b", gv, oh(ex)); end
        wait_done(dv, r, e, cd);
        n_cmp++; if (r !== P2'(15)) begin n_bad++; $display("FAIL mid_next_result: got %0d want 15", r); end
        n_cmp++; if (cd - cg != L + 3) begin n_bad++; $display("FAIL mid_next_lat: got %0d want %0d", cd - cg, L + 3); end
        @(negedge clock);
    endtask

    task automatic test_random();
        logic [N-1:0]  gv, dv, pend;
        logic [P2-1:0] r, xr;
        logic          e, ms;
        int            cg, cd, ex, xl;
        int            ea [N];
        int            eb [N];
        for (int it = 0; it < 16; it++) begin
            pend = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                ea[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
                eb[i] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
                set_op(i, ea[i], eb[i]);
            end
            req = pend;
            for (int g = 0; g < N && pend != 0; g++) begin
                ex       = pick(pend, mptr);
                mptr     = (ex + 1) % N;
                pend[ex] = 1'b0;
                xr       = P2'(ea[ex] * eb[ex]);
                xl       = (ea[ex] == 0 || eb[ex] == 0) ? 2 : L + 3;
                wait_gnt(gv, cg, ms);
                req[ex] = 1'b0;
                n_cmp++; if (gv !== oh(ex)) begin n_bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", it, gv, oh(ex)); end
                wait_done(dv, r, e, cd);
                n_cmp++; if (dv !== oh(ex)) begin n_bad++; $display("FAIL rnd_done[%0d]: got %b want %b", it, dv, oh(ex)); end
                n_cmp++; if (r !== xr) begin n_bad++; $display("FAIL rnd_result[%0d]: got %0d want %0d", it, r, xr); end
                n_cmp++; if (cd - cg != xl) begin n_bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", it, cd - cg, xl); end
                n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want 0", it, e); end
            end
            req = '0;
            @(negedge clock);
            n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL rnd_pulse[%0d]: got %b want 0", it, done); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero();
        test_wrap();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
